// File: rtl/arty_reset_ctrl_if.sv
// Signal bundle between arty_reset_ctrl and its surroundings:
// lock/button/CPU reset requests in, sequenced resets and the reset cause out.
interface arty_reset_ctrl_if;
    logic       mmcm_locked;
    logic       btn_resetn;
    logic       cpu_sysresetreq;
    logic       cpu_lockup;
    logic       mmcm_resetn;
    logic       bus_resetn;
    logic       cpu_resetn;
    logic       sys_ready;
    logic [3:0] reset_cause;

    modport master (
        output mmcm_locked, btn_resetn, cpu_sysresetreq, cpu_lockup,
        input  mmcm_resetn, bus_resetn, cpu_resetn, sys_ready, reset_cause
    );

    modport slave (
        input  mmcm_locked, btn_resetn, cpu_sysresetreq, cpu_lockup,
        output mmcm_resetn, bus_resetn, cpu_resetn, sys_ready, reset_cause
    );
endinterface

// File: rtl/arty_reset_ctrl.sv
// Reset sequencer for the clk_50m domain: pulses the MMCM reset, waits for a stable lock,
// then releases the bus reset followed by the CPU reset, and records why the last reset happened.
module arty_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MMCM_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int HOLD_CYCLES     = 64,
    parameter int CPU_DELAY       = 8,
    parameter bit LOCKUP_RST_EN   = 1'b1
) (
    input  logic             clk_50m,
    input  logic             reset,
    arty_reset_ctrl_if.slave io_ctrl
);

    localparam int MAX_A   = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (HOLD_CYCLES > CPU_DELAY) ? HOLD_CYCLES : CPU_DELAY;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MMCM_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] CAUSE_POR  = 4'b0001;
    localparam logic [3:0] CAUSE_BTN  = 4'b0010;
    localparam logic [3:0] CAUSE_LOCK = 4'b0100;
    localparam logic [3:0] CAUSE_SW   = 4'b1000;

    typedef enum logic [2:0] {
        ST_MMCM_RST,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_BUS_UP,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   w_lock_s;
    logic                   w_btn_s;

    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_db_armed;
    logic                   w_db_break;
    logic                   w_db_hit;
    logic                   w_btn_press;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [3:0]             r_cause;
    logic [3:0]             w_cause_nxt;
    logic                   w_sw_req;

    logic                   r_mmcm_resetn;
    logic                   r_bus_resetn;
    logic                   r_cpu_resetn;
    logic                   r_sys_ready;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '1;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], io_ctrl.mmcm_locked};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], io_ctrl.btn_resetn};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

    // One counter serves both directions: armed counts low samples, disarmed counts high ones.
    assign w_db_break  = (r_db_armed == w_btn_s);
    assign w_db_hit    = (r_db_cnt == DB_LAST);
    assign w_btn_press = r_db_armed && !w_btn_s && w_db_hit;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_db_armed <= 1'b1;
        end else if (w_db_break) begin
            r_db_cnt   <= '0;
        end else if (w_db_hit) begin
            r_db_cnt   <= '0;
            r_db_armed <= !r_db_armed;
        end else if (r_db_cnt != {DB_W{1'b1}}) begin
            r_db_cnt   <= r_db_cnt + 1'b1;
        end
    end

    assign w_sw_req  = io_ctrl.cpu_sysresetreq || (LOCKUP_RST_EN && io_ctrl.cpu_lockup);
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_MMCM_RST: begin
                if (w_btn_press) begin
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_BTN;
                end else if (r_cnt == MMCM_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_btn_press) begin
                    w_state_nxt = ST_MMCM_RST;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_BTN;
                end else if (w_lock_s) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = ST_MMCM_RST;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_LOCK;
                end
            end
            ST_HOLD: begin
                if (w_btn_press) begin
                    w_state_nxt = ST_MMCM_RST;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_BTN;
                end else if (!w_lock_s) begin
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_BUS_UP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUS_UP: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_LOCK;
                end else if (w_btn_press) begin
                    w_state_nxt = ST_MMCM_RST;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_BTN;
                end else if (r_cnt == CPU_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cause_nxt = CAUSE_LOCK;
                end else if (w_btn_press) begin
                    w_state_nxt = ST_MMCM_RST;
                    w_cause_nxt = CAUSE_BTN;
                end else if (w_sw_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cause_nxt = CAUSE_SW;
                end
            end
            default: begin
                w_state_nxt = ST_MMCM_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            r_state       <= ST_MMCM_RST;
            r_cnt         <= '0;
            r_cause       <= CAUSE_POR;
            r_mmcm_resetn <= 1'b0;
            r_bus_resetn  <= 1'b0;
            r_cpu_resetn  <= 1'b0;
            r_sys_ready   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cause       <= w_cause_nxt;
            r_mmcm_resetn <= (w_state_nxt != ST_MMCM_RST);
            r_bus_resetn  <= (w_state_nxt == ST_BUS_UP) || (w_state_nxt == ST_RUN);
            r_cpu_resetn  <= (w_state_nxt == ST_RUN);
            r_sys_ready   <= (w_state_nxt == ST_RUN);
        end
    end

    assign io_ctrl.mmcm_resetn = r_mmcm_resetn;
    assign io_ctrl.bus_resetn  = r_bus_resetn;
    assign io_ctrl.cpu_resetn  = r_cpu_resetn;
    assign io_ctrl.sys_ready   = r_sys_ready;
    assign io_ctrl.reset_cause = r_cause;

endmodule
